// File: rtl/register_schem.sv
// 16 x 16-bit register file: one synchronous write port, two combinational
// read ports and a continuous copy of every register for debug observation.
module register_schem (
    input  logic        clock,
    input  logic        rst,
    input  logic        Write,
    input  logic [15:0] data,
    input  logic [3:0]  select,
    input  logic [3:0]  selecta,
    input  logic [3:0]  selectb,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [15:0] regk,
    output logic [15:0] regl,
    output logic [15:0] regm,
    output logic [15:0] regn,
    output logic [15:0] rego,
    output logic [15:0] regp,
    output logic [15:0] regq,
    output logic [15:0] regr,
    output logic [15:0] regs,
    output logic [15:0] regt,
    output logic [15:0] regu,
    output logic [15:0] regv,
    output logic [15:0] regw,
    output logic [15:0] regx,
    output logic [15:0] regy,
    output logic [15:0] regz
);

    logic [15:0] reg_file [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg
            logic [15:0] reg_q;
            logic [15:0] reg_d;
            logic        wen;

            assign wen = Write && (select == 4'(gi));

            always_comb begin
                reg_d = reg_q;
                if (wen) begin
                    reg_d = data;
                end
            end

            // Reset wins over a coincident write because it is evaluated first.
            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    reg_q <= 16'h0000;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign reg_file[gi] = reg_q;
        end
    endgenerate

    // Reads are purely combinational; there is no bypass of write data.
    assign a = reg_file[selecta];
    assign b = reg_file[selectb];

    assign regk = reg_file[0];
    assign regl = reg_file[1];
    assign regm = reg_file[2];
    assign regn = reg_file[3];
    assign rego = reg_file[4];
    assign regp = reg_file[5];
    assign regq = reg_file[6];
    assign regr = reg_file[7];
    assign regs = reg_file[8];
    assign regt = reg_file[9];
    assign regu = reg_file[10];
    assign regv = reg_file[11];
    assign regw = reg_file[12];
    assign regx = reg_file[13];
    assign regy = reg_file[14];
    assign regz = reg_file[15];

endmodule

// File: tb/tb_register_schem.sv
// Directed bench for register_schem: reset behaviour, write sweep, write
// disable, read-during-write and dual-port reads, with a vector table.
module tb_register_schem;

    logic        clock;
    logic        rst;
    logic        Write;
    logic [15:0] data;
    logic [3:0]  select;
    logic [3:0]  selecta;
    logic [3:0]  selectb;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] dbg [16];

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl [16];

    register_schem dut (
        .clock   (clock),
        .rst     (rst),
        .Write   (Write),
        .data    (data),
        .select  (select),
        .selecta (selecta),
        .selectb (selectb),
        .a       (a),
        .b       (b),
        .regk    (dbg[0]),
        .regl    (dbg[1]),
        .regm    (dbg[2]),
        .regn    (dbg[3]),
        .rego    (dbg[4]),
        .regp    (dbg[5]),
        .regq    (dbg[6]),
        .regr    (dbg[7]),
        .regs    (dbg[8]),
        .regt    (dbg[9]),
        .regu    (dbg[10]),
        .regv    (dbg[11]),
        .regw    (dbg[12]),
        .regx    (dbg[13]),
        .regy    (dbg[14]),
        .regz    (dbg[15])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [15:0] wdata;
        logic [3:0]  sela;
        logic [3:0]  selb;
        logic [15:0] exp_pre;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            check16($sformatf("%s reg[%0d]", tag, i), dbg[i], mdl[i]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd7,  16'h0011, 4'd7,  4'd7,  16'h1007, 16'h0011, 16'h0011};
        vecs[1] = '{1'b1, 4'd7,  16'h2222, 4'd7,  4'd0,  16'h0011, 16'h2222, 16'h1000};
        vecs[2] = '{1'b1, 4'd15, 16'hA5A5, 4'd15, 4'd15, 16'h100F, 16'hA5A5, 16'hA5A5};
        vecs[3] = '{1'b0, 4'd15, 16'h0000, 4'd15, 4'd15, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vecs[4] = '{1'b1, 4'd0,  16'hBEEF, 4'd0,  4'd15, 16'h1000, 16'hBEEF, 16'hA5A5};
        vecs[5] = '{1'b1, 4'd9,  16'hFFFF, 4'd9,  4'd0,  16'h1009, 16'hFFFF, 16'hBEEF};

        rst = 1'b1; Write = 1'b0; data = 16'h0; select = 4'd0; selecta = 4'd0; selectb = 4'd0;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        #12;
        check_all("por");
        check16("por a", a, 16'h0000);
        rst = 1'b0;
        tick();

        // Fill with ones, then pulse reset mid-cycle.
        for (int i = 0; i < 16; i++) begin
            Write = 1'b1; select = 4'(i); data = 16'hFFFF;
            tick();
            mdl[i] = 16'hFFFF;
        end
        Write = 1'b0;
        check_all("ones");
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        check_all("async rst");
        check16("async rst a", a, 16'h0000);
        check16("async rst b", b, 16'h0000);
        #4 rst = 1'b0;
        tick();

        // Write while reset held is ignored.
        rst = 1'b1; Write = 1'b1; select = 4'd4; data = 16'h7777;
        tick();
        check16("held rst rego", dbg[4], 16'h0000);
        rst = 1'b0; Write = 1'b0;
        tick();

        // Sweep writes.
        for (int i = 0; i < 16; i++) begin
            Write = 1'b1; select = 4'(i); data = 16'h1000 + 16'(i);
            tick();
            mdl[i] = 16'h1000 + 16'(i);
            check_all($sformatf("sweep%0d", i));
        end
        Write = 1'b0;
        selecta = 4'd3; selectb = 4'd12;
        #1;
        check16("sweep a", a, 16'h1003);
        check16("sweep b", b, 16'h100C);

        // Write disabled over several edges.
        Write = 1'b0; select = 4'd5; data = 16'hBEEF;
        repeat (3) tick();
        check_all("wdis");

        // Table vectors: pre-edge value of a, post-edge a and b.
        for (int v = 0; v < 6; v++) begin
            Write = vecs[v].we; select = vecs[v].sel; data = vecs[v].wdata;
            selecta = vecs[v].sela; selectb = vecs[v].selb;
            #1;
            check16($sformatf("vec%0d a pre", v), a, vecs[v].exp_pre);
            tick();
            if (vecs[v].we) mdl[vecs[v].sel] = vecs[v].wdata;
            check16($sformatf("vec%0d a post", v), a, vecs[v].exp_a);
            check16($sformatf("vec%0d b post", v), b, vecs[v].exp_b);
        end
        Write = 1'b0;
        check_all("table");

        // Same-address dual read, then move selectb with no clock edge.
        selecta = 4'd15; selectb = 4'd15;
        #1;
        check16("dual a", a, 16'hA5A5);
        check16("dual b", b, 16'hA5A5);
        selectb = 4'd0;
        #1;
        check16("dual b moved", b, 16'hBEEF);
        check16("dual a kept", a, 16'hA5A5);

        // Reset coincident with a write edge.
        @(negedge clock);
        Write = 1'b1; select = 4'd2; data = 16'h1234;
        #4 rst = 1'b1;
        tick();
        check16("rst vs write regm", dbg[2], 16'h0000);
        rst = 1'b0; Write = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        tick();
        check_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
